update_dispatcher: RTL and testbench

- Upstream feeder for the arbitrage graph container. Accepts edge-weight updates from the HPS over a small Avalon-MM slave, and buffers them in a FIFO.
- Issues the updates one at a time to the container: drives container_reset, u_src, u_dst, u_e and src, then waits for container_done.
- Serialises updates so that each Bellman-Ford / cycle-detect pass sees exactly one edge change.
- Reports occupancy, busy, overflow and timeout status back to software.

---
 rtl/hft_pkg.sv | 45 ++++
 rtl/update_fifo.sv | 59 +++++
 rtl/update_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_update_dispatcher.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared types and constants for the update dispatcher and its FIFO.
package hft_pkg;

  localparam int V_BITS_DFLT = 5;
  localparam int W_BITS_DFLT = 32;

  // One edge-weight update as queued for the container.
  typedef struct packed {
    logic [V_BITS_DFLT-1:0] src;
    logic [V_BITS_DFLT-1:0] dst;
    logic [W_BITS_DFLT-1:0] weight;
  } update_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } disp_state_t;

  localparam logic [1:0] ADDR_WEIGHT = 2'd0;
  localparam logic [1:0] ADDR_PUSH   = 2'd1;
  localparam logic [1:0] ADDR_SRC    = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  // Status word layout returned on every read.
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_COUNT_W   = 7;
  localparam int ST_BUSY      = 7;
  localparam int ST_OVERFLOW  = 8;
  localparam int ST_TIMEOUT   = 9;

  function automatic logic [31:0] pack_status(input logic                  timeout,
                                              input logic                  overflow,
                                              input logic                  busy,
                                              input logic [ST_COUNT_W-1:0] count);
    logic [31:0] s;
    s = '0;
    s[ST_COUNT_LSB +: ST_COUNT_W] = count;
    s[ST_BUSY]     = busy;
    s[ST_OVERFLOW] = overflow;
    s[ST_TIMEOUT]  = timeout;
    return s;
  endfunction

endpackage

// File: rtl/update_fifo.sv
// Synchronous FIFO of pending updates. A push on a full FIFO is accepted
// only if a pop happens in the same cycle; dropped pushes are flagged by
// the parent, not here.
module update_fifo
  import hft_pkg::*;
#(
  parameter type entry_t    = update_t,
  parameter int  DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  entry_t              push_data_i,
  input  logic                pop_i,
  output entry_t              head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage write; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/update_dispatcher.sv
// Feeds edge-weight updates from the HPS to the graph container one at a
// time, so every Bellman-Ford pass sees exactly one edge change.
//
// state | meaning
// IDLE  | container held in reset, waiting for a queued update
// LOAD  | pop head into output registers, container still in reset
// RUN   | container running on held outputs until done or timeout
module update_dispatcher
  import hft_pkg::*;
#(
  parameter int V_BITS     = V_BITS_DFLT,
  parameter int W_BITS     = W_BITS_DFLT,
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 2 ** 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [1:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [V_BITS-1:0] src,
  output logic [V_BITS-1:0] u_src,
  output logic [V_BITS-1:0] u_dst,
  output logic [W_BITS-1:0] u_e,
  output logic              container_reset,
  input  logic              container_done,
  output logic              busy
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [V_BITS-1:0] src;
    logic [V_BITS-1:0] dst;
    logic [W_BITS-1:0] weight;
  } upd_t;

  disp_state_t         state_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [W_BITS-1:0]   weight_latch_q;
  logic [V_BITS-1:0]   src_reg_q;
  logic [V_BITS-1:0]   src_q;
  logic [V_BITS-1:0]   u_src_q;
  logic [V_BITS-1:0]   u_dst_q;
  logic [W_BITS-1:0]   u_e_q;
  logic                container_reset_q;
  logic                busy_q;
  logic [31:0]         readdata_q;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;

  logic                wr_en;
  logic                rd_en;
  logic                push;
  logic                pop;
  logic                timeout_hit;
  upd_t                push_data;
  upd_t                fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;
  assign push  = wr_en && (address == ADDR_PUSH);
  assign pop   = (state_q == LOAD);

  assign push_data.src    = writedata[2*V_BITS-1:V_BITS];
  assign push_data.dst    = writedata[V_BITS-1:0];
  assign push_data.weight = weight_latch_q;

  assign timeout_hit = (state_q == RUN) && !container_done && (timer_q == TIMER_LIMIT);

  update_fifo #(
    .entry_t   (upd_t),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Sticky flags: software clears, hardware events win over a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (wr_en && (address == ADDR_CLEAR)) begin
      if (writedata[0]) overflow_d = 1'b0;
      if (writedata[1]) timeout_d  = 1'b0;
    end
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (timeout_hit) timeout_d = 1'b1;
  end

  // Software-visible registers: weight latch, src staging, sticky flags, read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      weight_latch_q <= '0;
      src_reg_q      <= '0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
      readdata_q     <= '0;
    end else begin
      if (wr_en && (address == ADDR_WEIGHT)) weight_latch_q <= writedata[W_BITS-1:0];
      if (wr_en && (address == ADDR_SRC))    src_reg_q      <= writedata[V_BITS-1:0];
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      if (rd_en) readdata_q <= pack_status(timeout_q, overflow_q, busy_q, ST_COUNT_W'(fifo_count));
    end
  end

  // Sequencer: hold the container in reset until an update is loaded, then
  // run it until done or timeout. IDLE+LOAD guarantee two reset cycles per gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      timer_q           <= '0;
      container_reset_q <= 1'b1;
      busy_q            <= 1'b0;
      src_q             <= '0;
      u_src_q           <= '0;
      u_dst_q           <= '0;
      u_e_q             <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          container_reset_q <= 1'b1;
          busy_q            <= 1'b0;
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          u_src_q           <= fifo_head.src;
          u_dst_q           <= fifo_head.dst;
          u_e_q             <= fifo_head.weight;
          src_q             <= src_reg_q;
          timer_q           <= '0;
          container_reset_q <= 1'b0;
          busy_q            <= 1'b1;
          state_q           <= RUN;
        end
        RUN: begin
          if (container_done || timeout_hit) begin
            container_reset_q <= 1'b1;
            busy_q            <= 1'b0;
            state_q           <= IDLE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: begin
          container_reset_q <= 1'b1;
          busy_q            <= 1'b0;
          state_q           <= IDLE;
        end
      endcase
    end
  end

  assign readdata        = readdata_q;
  assign src             = src_q;
  assign u_src           = u_src_q;
  assign u_dst           = u_dst_q;
  assign u_e             = u_e_q;
  assign container_reset = container_reset_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_update_dispatcher.sv
// Self-checking bench for update_dispatcher: a vector table for single
// updates, a scoreboard of expected issued updates, and hand sequences for
// queueing, timeout, overflow and asynchronous reset.
module tb_update_dispatcher;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [4:0]  src;
  logic [4:0]  u_src;
  logic [4:0]  u_dst;
  logic [31:0] u_e;
  logic        container_reset;
  logic        container_done;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int done_delay = 0;

  typedef struct {
    logic [4:0]  us;
    logic [4:0]  ud;
    logic [4:0]  s;
    logic [31:0] e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  update_dispatcher #(
    .V_BITS    (5),
    .W_BITS    (32),
    .DEPTH_LOG2(3),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .src            (src),
    .u_src          (u_src),
    .u_dst          (u_dst),
    .u_e            (u_e),
    .container_reset(container_reset),
    .container_done (container_done),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_busy(input logic val, input int max, input string name, output int n);
    n = 0;
    while (busy !== val && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== val) begin
      tests++; fails++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected %0b", name, busy, n, val);
    end
  endtask

  // Container model: raises done after done_delay RUN cycles (0 = never).
  initial begin : container_model
    int run_cyc;
    run_cyc = 0;
    container_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && !container_reset) begin
        run_cyc++;
        container_done = (done_delay != 0) && (run_cyc == done_delay);
      end else begin
        run_cyc = 0;
        container_done = 1'b0;
      end
    end
  end

  // Issue monitor: each run start pops the scoreboard; each run end checks
  // the outputs stayed put; every gap must hold container_reset >= 2 cycles.
  initial begin : issue_monitor
    logic prev_cr;
    int   hi_cnt;
    exp_t cur;
    exp_t e;
    prev_cr = 1'b1;
    hi_cnt  = 0;
    cur     = '{5'd0, 5'd0, 5'd0, 32'd0};
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev_cr = 1'b1;
        hi_cnt  = 0;
      end else begin
        if (container_reset) begin
          if (!prev_cr) begin
            check("held_u_src", {27'd0, u_src}, {27'd0, cur.us});
            check("held_u_e", u_e, cur.e);
          end
          hi_cnt++;
        end else if (prev_cr) begin
          check("reset_gap_ge2", (hi_cnt >= 2) ? 32'd1 : 32'd0, 32'd1);
          hi_cnt = 0;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_run: u_src=%0d u_dst=%0d with no update expected", u_src, u_dst);
          end else begin
            e   = sb.pop_front();
            cur = e;
            check("u_src", {27'd0, u_src}, {27'd0, e.us});
            check("u_dst", {27'd0, u_dst}, {27'd0, e.ud});
            check("src",   {27'd0, src},   {27'd0, e.s});
            check("u_e",   u_e,            e.e);
          end
        end
        prev_cr = container_reset;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] wd_w;
    logic [31:0] wd_s;
    logic [31:0] wd_p;
    int          dly;
    logic [4:0]  us;
    logic [4:0]  ud;
    logic [4:0]  s;
    logic [31:0] e;
  } vec_t;

  initial begin : main
    vec_t        vecs[4];
    int          n;
    logic [31:0] rdv;

    vecs[0] = '{32'hFFFFFF9C, 32'd3,        32'h00000047, 50, 5'd2,  5'd7,  5'd3,  32'hFFFFFF9C};
    vecs[1] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  5'd31, 5'd31, 5'd31, 32'h7FFFFFFF};
    vecs[2] = '{32'h80000000, 32'd0,        32'h00000020, 1,  5'd1,  5'd0,  5'd0,  32'h80000000};
    vecs[3] = '{32'h00000000, 32'h00000045, 32'hABCD0229, 5,  5'd17, 5'd9,  5'd5,  32'h00000000};

    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 2'd0; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_container_reset", {31'd0, container_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_u_e", u_e, 32'd0);
    check("rst_ids", {17'd0, u_src, u_dst, src}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, rdv);
    check("status_after_reset", rdv, 32'd0);

    // Single updates, one at a time from an idle, empty dispatcher.
    for (int i = 0; i < 4; i++) begin
      done_delay = vecs[i].dly;
      wr(2'd0, vecs[i].wd_w);
      wr(2'd2, vecs[i].wd_s);
      sb.push_back('{vecs[i].us, vecs[i].ud, vecs[i].s, vecs[i].e});
      wr(2'd1, vecs[i].wd_p);
      n = 0;
      while (container_reset && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check("load_latency", n, 32'd2);
      check("busy_in_run", {31'd0, busy}, 32'd1);
      n = 0;
      while (!container_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      check("reset_after_done", {31'd0, container_reset}, 32'd1);
      check("busy_after_done", {31'd0, busy}, 32'd0);
    end
    rd(2'd3, rdv);
    check("status_idle", rdv, 32'd0);

    // Queueing: three updates pushed while one is running.
    done_delay = 30;
    wr(2'd0, 32'h00001234);
    wr(2'd2, 32'd4);
    sb.push_back('{5'd1, 5'd2, 5'd4, 32'h00001234});
    wr(2'd1, (32'd1 << 5) | 32'd2);
    wait_busy(1'b1, 10, "q_first_start", n);
    wr(2'd0, 32'hFFFF0000);
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{5'(3 + 2*k), 5'(4 + 2*k), 5'd4, 32'hFFFF0000});
      wr(2'd1, (32'(3 + 2*k) << 5) | 32'(4 + 2*k));
    end
    rd(2'd2, rdv);
    check("q_status_count3", rdv, 32'h00000083);
    for (int k = 2; k >= 0; k--) begin
      wait_busy(1'b0, 60, "q_run_end", n);
      wait_busy(1'b1, 10, "q_run_start", n);
      rd(2'd1, rdv);
      check("q_status_count", rdv, 32'h00000080 | 32'(k));
    end
    wait_busy(1'b0, 60, "q_drain", n);

    // Timeout: container never answers; next queued update must still issue.
    done_delay = 0;
    wr(2'd0, 32'hDEADBEEF);
    wr(2'd2, 32'd9);
    sb.push_back('{5'd10, 5'd11, 5'd9, 32'hDEADBEEF});
    wr(2'd1, (32'd10 << 5) | 32'd11);
    sb.push_back('{5'd12, 5'd13, 5'd9, 32'hDEADBEEF});
    wr(2'd1, (32'd12 << 5) | 32'd13);
    wait_busy(1'b1, 10, "to_start", n);
    wait_busy(1'b0, TIMEOUT + 10, "to_end", n);
    check("timeout_run_cycles", n, 32'(TIMEOUT));
    done_delay = 5;
    check("timeout_reset_high", {31'd0, container_reset}, 32'd1);
    rd(2'd0, rdv);
    check("timeout_status", rdv, 32'h00000201);
    wait_busy(1'b1, 10, "to_next_start", n);
    wait_busy(1'b0, 20, "to_next_end", n);
    check("done_run_cycles", n, 32'd5);
    wr(2'd3, 32'd2);
    rd(2'd0, rdv);
    check("timeout_cleared", rdv, 32'd0);

    // Overflow: container held busy, 9 pushes into an 8-deep FIFO.
    done_delay = 0;
    wr(2'd0, 32'h00000055);
    wr(2'd2, 32'd1);
    sb.push_back('{5'd0, 5'd1, 5'd1, 32'h00000055});
    wr(2'd1, 32'd1);
    wait_busy(1'b1, 10, "ovf_occupant_start", n);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) sb.push_back('{5'(k + 2), 5'(k + 3), 5'd1, 32'h00000055});
      wr(2'd1, (32'(k + 2) << 5) | 32'(k + 3));
    end
    rd(2'd0, rdv);
    check("ovf_status", rdv, 32'h00000188);
    wr(2'd3, 32'd1);
    rd(2'd0, rdv);
    check("ovf_cleared", rdv, 32'h00000088);

    // Full FIFO, push on the LOAD cycle: both succeed, no overflow.
    wait_busy(1'b0, TIMEOUT + 10, "ovf_occupant_end", n);
    @(posedge clk); #1;
    sb.push_back('{5'd20, 5'd21, 5'd1, 32'h00000055});
    wr(2'd1, (32'd20 << 5) | 32'd21);
    rd(2'd0, rdv);
    check("full_push_pop_status", rdv, 32'h00000288);

    // Asynchronous reset between clock edges during a run.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_container_reset", {31'd0, container_reset}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ids", {17'd0, u_src, u_dst, src}, 32'd0);
    check("arst_u_e", u_e, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, rdv);
    check("arst_status", rdv, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_run", {31'd0, container_reset}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
